// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, memory-wait timeout, retire counter.
// Optional build macro MULTICYCLE_CTRL_TRAP_EN sends unknown opcodes to a terminal TRAP state instead of a NOP.
module multicycle_ctrl #(
   parameter int unsigned MEM_WAIT_MAX = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  opcode,
   input  logic        branch_taken,
   input  logic        mem_ready,
   output logic        pc_update,
   output logic [1:0]  pc_src,
   output logic        ir_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        iord,
   output logic        reg_write,
   output logic [2:0]  state,
   output logic [31:0] instr_count,
   output logic        mem_err
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      C_LOAD,
      C_STORE,
      C_ALU,
      C_BRANCH,
      C_JAL,
      C_JALR,
      C_SYSTEM,
      C_UNKNOWN
   } cls_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [1:0] PC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_TARGET = 2'd1;
   localparam logic [1:0] PC_ALU    = 2'd2;

   // Timeout fires on the low cycle that would bring the count up to MEM_WAIT_MAX.
   localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

   state_t      state_q;
   state_t      state_d;
   cls_t        cls;
   logic [7:0]  wait_q;
   logic        retire;
   logic        timeout;
   logic        waiting;

   always_comb begin
      cls = C_UNKNOWN;
      case (opcode)
         OPC_LOAD:   cls = C_LOAD;
         OPC_STORE:  cls = C_STORE;
         OPC_OP,
         OPC_OPIMM,
         OPC_LUI,
         OPC_AUIPC:  cls = C_ALU;
         OPC_BRANCH: cls = C_BRANCH;
         OPC_JAL:    cls = C_JAL;
         OPC_JALR:   cls = C_JALR;
         OPC_SYSTEM: cls = C_SYSTEM;
         default:    cls = C_UNKNOWN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_update = 1'b0;
      pc_src    = PC_PLUS4;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      iord      = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
      timeout   = 1'b0;
      waiting   = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write  = 1'b1;
               pc_update = 1'b1;
               state_d   = S_DECODE;
            end else begin
               waiting = 1'b1;
               if (wait_q == WAIT_LAST) begin
                  timeout = 1'b1;
                  state_d = S_HALT;
               end
            end
         end

         S_DECODE: begin
            case (cls)
               C_SYSTEM:  state_d = S_HALT;
`ifdef MULTICYCLE_CTRL_TRAP_EN
               C_UNKNOWN: state_d = S_TRAP;
`else
               C_UNKNOWN: begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
`endif
               default:   state_d = S_EXEC;
            endcase
         end

         S_EXEC: begin
            case (cls)
               C_BRANCH: begin
                  pc_src    = PC_TARGET;
                  pc_update = branch_taken;
                  state_d   = S_FETCH;
                  retire    = 1'b1;
               end
               C_JAL: begin
                  pc_src    = PC_TARGET;
                  pc_update = 1'b1;
                  state_d   = S_WB;
               end
               C_JALR: begin
                  pc_src    = PC_ALU;
                  pc_update = 1'b1;
                  state_d   = S_WB;
               end
               C_LOAD,
               C_STORE:  state_d = S_MEM;
               C_ALU:    state_d = S_WB;
               default:  state_d = S_FETCH;
            endcase
         end

         S_MEM: begin
            iord      = 1'b1;
            mem_read  = (cls == C_LOAD);
            mem_write = (cls == C_STORE);
            if (mem_ready) begin
               if (cls == C_LOAD) begin
                  state_d = S_WB;
               end else begin
                  state_d = S_FETCH;
                  retire  = (cls == C_STORE);
               end
            end else begin
               waiting = 1'b1;
               if (wait_q == WAIT_LAST) begin
                  timeout = 1'b1;
                  state_d = S_HALT;
               end
            end
         end

         S_WB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
            retire    = 1'b1;
         end

         S_HALT,
         S_TRAP: state_d = state_q;

         default: state_d = S_FETCH;
      endcase

      // While reset is held the outputs must show a quiet FETCH, whatever mem_ready does.
      if (!rst) begin
         pc_update = 1'b0;
         pc_src    = PC_PLUS4;
         ir_write  = 1'b0;
         mem_read  = 1'b1;
         mem_write = 1'b0;
         iord      = 1'b0;
         reg_write = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_q <= '0;
      end else if (state_d != state_q) begin
         wait_q <= '0;
      end else if (waiting) begin
         wait_q <= wait_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instr_count <= '0;
         mem_err     <= 1'b0;
      end else begin
         if (retire) begin
            instr_count <= instr_count + 32'd1;
         end
         if (timeout) begin
            mem_err <= 1'b1;
         end
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; define MULTICYCLE_CTRL_TRAP_EN to check the TRAP build.
module tb_multicycle_ctrl;

   logic        clk;
   logic        rst;
   logic [6:0]  opcode;
   logic        branch_taken;
   logic        mem_ready;
   logic        pc_update;
   logic [1:0]  pc_src;
   logic        ir_write;
   logic        mem_read;
   logic        mem_write;
   logic        iord;
   logic        reg_write;
   logic [2:0]  state;
   logic [31:0] instr_count;
   logic        mem_err;

   int tests_run = 0;
   int fails     = 0;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_BAD    = 7'b1111111;

   // obs = {state, pc_update, pc_src, ir_write, mem_read, mem_write, iord, reg_write}
   logic [10:0] obs;
   logic [10:0] exp_obs;
   assign obs = {state, pc_update, pc_src, ir_write, mem_read, mem_write, iord, reg_write};

   multicycle_ctrl #(.MEM_WAIT_MAX(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .opcode       (opcode),
      .branch_taken (branch_taken),
      .mem_ready    (mem_ready),
      .pc_update    (pc_update),
      .pc_src       (pc_src),
      .ir_write     (ir_write),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .iord         (iord),
      .reg_write    (reg_write),
      .state        (state),
      .instr_count  (instr_count),
      .mem_err      (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b0;
      #1;
      rst = 1'b1;
   endtask

   task automatic enter_exec(input logic [6:0] op);
      opcode    = op;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      rst = 1'b0; mem_ready = 1'b1; opcode = OP_OP; branch_taken = 1'b1;
      #1;
      exp_obs = {3'd0, 8'b0000_1000};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL reset_outputs obs=%b exp=%b", obs, exp_obs); end
      tests_run++; if (instr_count !== 32'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
      tests_run++; if (mem_err !== 1'b0) begin fails++; $display("FAIL reset_mem_err got=%b exp=0", mem_err); end
      tick(); tick();
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL reset_held obs=%b exp=%b", obs, exp_obs); end
      branch_taken = 1'b0;
      rst = 1'b1;
   endtask

   task automatic test_op;
      opcode = OP_OP; mem_ready = 1'b1;
      #1;
      exp_obs = {3'd0, 8'b1001_1000};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL op_fetch obs=%b exp=%b", obs, exp_obs); end
      tick(); mem_ready = 1'b0; #1;
      exp_obs = {3'd1, 8'b0000_0000};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL op_decode obs=%b exp=%b", obs, exp_obs); end
      tick(); #1;
      exp_obs = {3'd2, 8'b0000_0000};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL op_exec obs=%b exp=%b", obs, exp_obs); end
      tick(); #1;
      exp_obs = {3'd4, 8'b0000_0001};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL op_wb obs=%b exp=%b", obs, exp_obs); end
      tick(); #1;
      exp_obs = {3'd0, 8'b0000_1000};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL op_refetch obs=%b exp=%b", obs, exp_obs); end
      tests_run++; if (instr_count !== 32'd1) begin fails++; $display("FAIL op_count got=%0d exp=1", instr_count); end
   endtask

   task automatic test_load;
      enter_exec(OP_LOAD); #1;
      exp_obs = {3'd2, 8'b0000_0000};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL load_exec obs=%b exp=%b", obs, exp_obs); end
      tick();
      exp_obs = {3'd3, 8'b0000_1010};
      for (int i = 0; i < 3; i++) begin
         #1;
         tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL load_mem_wait%0d obs=%b exp=%b", i, obs, exp_obs); end
         tick();
      end
      mem_ready = 1'b1; #1;
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL load_mem_ready obs=%b exp=%b", obs, exp_obs); end
      tick(); mem_ready = 1'b0; #1;
      exp_obs = {3'd4, 8'b0000_0001};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL load_wb obs=%b exp=%b", obs, exp_obs); end
      tick(); #1;
      tests_run++; if (instr_count !== 32'd2) begin fails++; $display("FAIL load_count got=%0d exp=2", instr_count); end
   endtask

   task automatic test_store;
      enter_exec(OP_STORE); tick();
      mem_ready = 1'b1; #1;
      exp_obs = {3'd3, 8'b0000_0110};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL store_mem obs=%b exp=%b", obs, exp_obs); end
      tick(); mem_ready = 1'b0; #1;
      exp_obs = {3'd0, 8'b0000_1000};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL store_to_fetch obs=%b exp=%b", obs, exp_obs); end
      tests_run++; if (instr_count !== 32'd3) begin fails++; $display("FAIL store_count got=%0d exp=3", instr_count); end
   endtask

   task automatic test_branch;
      enter_exec(OP_BRANCH); branch_taken = 1'b1; #1;
      exp_obs = {3'd2, 8'b1010_0000};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL branch_taken obs=%b exp=%b", obs, exp_obs); end
      tick(); #1;
      exp_obs = {3'd0, 8'b0000_1000};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL branch_to_fetch obs=%b exp=%b", obs, exp_obs); end
      tests_run++; if (instr_count !== 32'd4) begin fails++; $display("FAIL branch_count got=%0d exp=4", instr_count); end
      enter_exec(OP_BRANCH); branch_taken = 1'b0; #1;
      exp_obs = {3'd2, 8'b0010_0000};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL branch_not_taken obs=%b exp=%b", obs, exp_obs); end
      tick(); #1;
      tests_run++; if (instr_count !== 32'd5) begin fails++; $display("FAIL branch_nt_count got=%0d exp=5", instr_count); end
   endtask

   task automatic test_jalr;
      enter_exec(OP_JALR); #1;
      exp_obs = {3'd2, 8'b1100_0000};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL jalr_exec obs=%b exp=%b", obs, exp_obs); end
      tick(); #1;
      exp_obs = {3'd4, 8'b0000_0001};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL jalr_wb obs=%b exp=%b", obs, exp_obs); end
      tick(); #1;
      tests_run++; if (instr_count !== 32'd6) begin fails++; $display("FAIL jalr_count got=%0d exp=6", instr_count); end
   endtask

   task automatic test_unknown;
      opcode = OP_BAD; mem_ready = 1'b1;
      tick(); mem_ready = 1'b0; #1;
      exp_obs = {3'd1, 8'b0000_0000};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL bad_decode obs=%b exp=%b", obs, exp_obs); end
      tick();
`ifdef MULTICYCLE_CTRL_TRAP_EN
      mem_ready = 1'b1;
      exp_obs = {3'd6, 8'b0000_0000};
      for (int i = 0; i < 3; i++) begin
         #1;
         tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL bad_trap%0d obs=%b exp=%b", i, obs, exp_obs); end
         tick();
      end
      tests_run++; if (instr_count !== 32'd6) begin fails++; $display("FAIL bad_trap_count got=%0d exp=6", instr_count); end
      mem_ready = 1'b0;
`else
      #1;
      exp_obs = {3'd0, 8'b0000_1000};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL bad_nop obs=%b exp=%b", obs, exp_obs); end
      tests_run++; if (instr_count !== 32'd7) begin fails++; $display("FAIL bad_nop_count got=%0d exp=7", instr_count); end
`endif
   endtask

   task automatic test_system;
      do_reset();
      opcode = OP_SYSTEM; mem_ready = 1'b1;
      tick(); tick(); #1;
      exp_obs = {3'd5, 8'b0000_0000};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL sys_halt obs=%b exp=%b", obs, exp_obs); end
      branch_taken = 1'b1; opcode = OP_OP;
      tick(); tick(); tick(); #1;
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL sys_halt_held obs=%b exp=%b", obs, exp_obs); end
      tests_run++; if (instr_count !== 32'd0) begin fails++; $display("FAIL sys_count got=%0d exp=0", instr_count); end
      branch_taken = 1'b0;
   endtask

   task automatic test_timeout;
      do_reset();
      mem_ready = 1'b0; opcode = OP_OP;
      repeat (7) tick();
      #1;
      exp_obs = {3'd0, 8'b0000_1000};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL tmo_wait7 obs=%b exp=%b", obs, exp_obs); end
      tests_run++; if (mem_err !== 1'b0) begin fails++; $display("FAIL tmo_err_early got=%b exp=0", mem_err); end
      tick(); #1;
      exp_obs = {3'd5, 8'b0000_0000};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL tmo_halt obs=%b exp=%b", obs, exp_obs); end
      tests_run++; if (mem_err !== 1'b1) begin fails++; $display("FAIL tmo_err got=%b exp=1", mem_err); end
      mem_ready = 1'b1;
      tick(); tick(); #1;
      tests_run++; if (mem_err !== 1'b1) begin fails++; $display("FAIL tmo_err_sticky got=%b exp=1", mem_err); end
      rst = 1'b0; #1;
      tests_run++; if (mem_err !== 1'b0) begin fails++; $display("FAIL tmo_err_reset got=%b exp=0", mem_err); end
      tests_run++; if (state !== 3'd0) begin fails++; $display("FAIL tmo_state_reset got=%0d exp=0", state); end
      rst = 1'b1;
   endtask

   task automatic test_ready_at_limit;
      mem_ready = 1'b0; opcode = OP_OP;
      repeat (7) tick();
      mem_ready = 1'b1; #1;
      exp_obs = {3'd0, 8'b1001_1000};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL lim_fetch obs=%b exp=%b", obs, exp_obs); end
      tick(); mem_ready = 1'b0; #1;
      exp_obs = {3'd1, 8'b0000_0000};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL lim_decode obs=%b exp=%b", obs, exp_obs); end
      tests_run++; if (mem_err !== 1'b0) begin fails++; $display("FAIL lim_err got=%b exp=0", mem_err); end
      tick(); tick(); tick();
   endtask

   task automatic test_mid_mem_reset;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         enter_exec(OP_OP);
         tick();
         tick();
      end
      #1;
      tests_run++; if (instr_count !== 32'd5) begin fails++; $display("FAIL mmr_count5 got=%0d exp=5", instr_count); end
      enter_exec(OP_STORE); tick(); #1;
      exp_obs = {3'd3, 8'b0000_0110};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL mmr_in_mem obs=%b exp=%b", obs, exp_obs); end
      rst = 1'b0; #1;
      exp_obs = {3'd0, 8'b0000_1000};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL mmr_reset obs=%b exp=%b", obs, exp_obs); end
      tests_run++; if (instr_count !== 32'd0) begin fails++; $display("FAIL mmr_count0 got=%0d exp=0", instr_count); end
      tests_run++; if (mem_err !== 1'b0) begin fails++; $display("FAIL mmr_err got=%b exp=0", mem_err); end
      mem_ready = 1'b1; opcode = OP_OP;
      tick(); #1;
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL mmr_held obs=%b exp=%b", obs, exp_obs); end
      rst = 1'b1; #1;
      exp_obs = {3'd0, 8'b1001_1000};
      tests_run++; if (obs !== exp_obs) begin fails++; $display("FAIL mmr_first_fetch obs=%b exp=%b", obs, exp_obs); end
      tick(); #1;
      tests_run++; if (state !== 3'd1) begin fails++; $display("FAIL mmr_decode got=%0d exp=1", state); end
      mem_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b0; opcode = '0; branch_taken = 1'b0; mem_ready = 1'b0;
      #2;
      test_reset();
      test_op();
      test_load();
      test_store();
      test_branch();
      test_jalr();
      test_unknown();
      test_system();
      test_timeout();
      test_ready_at_limit();
      test_mid_mem_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
